unshifter_seq: RTL and testbench
================================

Name: unshifter_seq

Overview:
- Sequential inverse of the team's combinational left shifter (y = a << b).
- Accepts a 7-bit shifted word `y` and its 2-bit shift amount `b` over a valid/ready handshake.
- Shifts right one position per clock and returns the original 4-bit operand `a`.
- Flags `err` when `y` is not a legal `a << b` encoding, meaning nonzero bits were lost or bits fall outside OUT_W.

Parameters:
- OUT_W, 4, width of the recovered operand `a`.
- SH_W, 2, width of the shift amount `b`.
- IN_W, 7, width of the input word. Must equal OUT_W + 2**SH_W - 1. Elaboration fails with $fatal otherwise.

Ports:
- clk  input  1  rising-edge clock; the single clock of the block.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  `y` and `b` are valid.
- in_ready  output  1  block can accept an input.
- y  input  IN_W  shifted word.
- b  input  SH_W  shift amount to undo.
- out_valid  output  1  `a` and `err` are valid.
- out_ready  input  1  consumer accepts the result.
- a  output  OUT_W  recovered operand.
- err  output  1  input was not a legal a<<b encoding.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- The FSM has three states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; the shift register, counter and sticky bit clear to 0.
  - Outputs: out_valid=0, a=0, err=0, busy=0.
  - in_ready is 0 while rst is high and 1 in the first cycle after rst drops.
  - Reset mid-operation discards the in-flight word. No output is produced for it.
- in_ready equals (state==IDLE) and !rst. It is combinational from state only, with no dependence on in_valid.
- Accept happens when in_valid && in_ready at a clk edge. On accept:
  - the shift register loads y;
  - the counter loads b;
  - the sticky bit clears.
- Next state after accept: DONE if b==0, otherwise SHIFT.
- In SHIFT, at each edge:
  - the register shifts right by 1 with zero fill;
  - sticky |= reg[0];
  - the counter decrements;
  - when the counter goes from 1 to 0, the next state is DONE.
- Latency: if accept occurs in cycle k, out_valid is first high in cycle k+b+1.
- In DONE:
  - out_valid=1;
  - a = reg[OUT_W-1:0];
  - err = sticky | (|reg[IN_W-1:OUT_W]).
- a and err are registered. They remain stable until the handshake completes.
- Output handshake: when out_valid && out_ready at an edge, the next state is IDLE and out_valid drops.
- in_ready is 0 in DONE, so no accept can occur in the same cycle as output consumption.
- Maximum throughput is one word per b+2 cycles.
- Backpressure: DONE is held indefinitely while out_ready=0. Inputs presented during SHIFT or DONE are ignored; the producer must hold them.
- Input changes on y or b while the block is not in IDLE have no effect.
- After the output handshake, a and err keep their last values. They are don't-care while out_valid=0, and the bench must not check them then.
- Arithmetic: a purely logical right shift with no sign extension. The register is IN_W bits wide; shift amounts up to 2**SH_W-1 are supported exactly.
- busy = (state != IDLE).

Test Plan:
- Legal word with shift: reset 3 cycles; then y=7'b0101100, b=2, in_valid=1 for one accept in cycle k.
  - Required: out_valid rises in cycle k+3; a=4'b1011, err=0; in_ready=0 in cycles k+1..k+3.
- Zero shift with upper-bit error: y=7'b0001111, b=0.
  - Required: out_valid in cycle k+1; a=4'b1111, err=0.
  - Then y=7'b1000000, b=0. Required: a=4'b0000, err=1.
- Lost low bit: y=7'b0101101, b=2.
  - Required: a=4'b1011, err=1.
  - Then y=7'b1111000, b=3. Required: a=4'b1111, err=0, out_valid in cycle k+4.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises.
  - Required: out_valid, a and err stay constant; in_ready=0; an input presented meanwhile is not accepted.
  - Then out_ready=1 for 1 cycle. Required: out_valid=0 and in_ready=1 in the next cycle.
- Reset mid-operation: y=7'b1111000, b=3, then assert rst in cycle k+2.
  - Required: the next cycle shows out_valid=0, a=0, err=0, busy=0.
  - No result for that word ever appears. The next legal transaction completes normally.
- Exhaustive round-trip: for all 16 values of a and all 4 values of b, drive y=a<<b with a random out_ready stall of 0-3 cycles.
  - Required: every result returns the original a with err=0, at latency b+1.
  - An independent monitor checks each case and reports failures with $error.

Source files
------------

// File: rtl/unshifter_seq.sv
// -----------------------------------------------------------------------------
// unshifter_seq
//
// Sequential inverse of the combinational left shifter (y = a << b). A shifted
// word and its shift amount are accepted over a valid/ready handshake. The word
// is shifted right one position per clock until the shift is undone, and the
// recovered operand is returned with an error flag. The flag is set when the
// word could not have come from a << b: either a nonzero bit was shifted out at
// the bottom, or nonzero bits remain above the OUT_W-bit result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   y and b are valid
//   in_ready   block can accept an input (IDLE and not in reset)
//   y          shifted word, IN_W bits
//   b          shift amount to undo, SH_W bits
//   out_valid  a and err are valid
//   out_ready  consumer accepts the result
//   a          recovered operand, OUT_W bits (registered)
//   err        input was not a legal a << b encoding (registered)
//   busy       high while a word is being shifted or its result is held
// -----------------------------------------------------------------------------
module unshifter_seq #(
    parameter int OUT_W = 4,
    parameter int SH_W  = 2,
    parameter int IN_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   y,
    input  logic [SH_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  a,
    output logic              err,
    output logic              busy
);

    // The register must be wide enough to hold the largest operand shifted
    // by the largest amount, and no wider.
    if (IN_W != OUT_W + 2**SH_W - 1) begin : g_width_check
        $fatal(1, "unshifter_seq: IN_W must equal OUT_W + 2**SH_W - 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [IN_W-1:0]     shreg;
    logic [SH_W-1:0]     cnt;
    logic                sticky;

    // Values the shift register and sticky bit take after one more SHIFT step.
    // Needed both for the register update and for the result captured on the
    // final step, so the result is registered in the same edge it is formed.
    logic [IN_W-1:0]     shreg_nxt;
    logic                sticky_nxt;

    assign shreg_nxt  = shreg >> 1;
    assign sticky_nxt = sticky | shreg[0];

    // A word is illegal if a set bit was lost at the bottom or if any set bit
    // remains above the recovered operand once the shift is fully undone.
    function automatic logic encode_err(input logic lost, input logic [IN_W-1:0] w);
        return lost | (|w[IN_W-1:OUT_W]);
    endfunction

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            a         <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is implied here since rst is low.
                    if (in_valid) begin
                        shreg  <= y;
                        cnt    <= b;
                        sticky <= 1'b0;
                        if (b == '0) begin
                            // Nothing to undo: the result is the word itself.
                            state     <= DONE;
                            out_valid <= 1'b1;
                            a         <= y[OUT_W-1:0];
                            err       <= encode_err(1'b0, y);
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    shreg  <= shreg_nxt;
                    sticky <= sticky_nxt;
                    cnt    <= cnt - SH_W'(1);
                    if (cnt == SH_W'(1)) begin
                        // Last step: capture the result from the post-shift
                        // values so it is valid on entry to DONE.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        a         <= shreg_nxt[OUT_W-1:0];
                        err       <= encode_err(sticky_nxt, shreg_nxt);
                    end
                end

                DONE: begin
                    // a and err are left untouched so they stay stable under
                    // backpressure and keep their last values afterwards.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unshifter_seq.sv
// -----------------------------------------------------------------------------
// tb_unshifter_seq
//
// Directed bench for unshifter_seq: a table of transactions with hand-computed
// results, hand-written reset and backpressure sequences, an exhaustive
// round-trip sweep, and an independent handshake monitor with its own model.
// -----------------------------------------------------------------------------
module tb_unshifter_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] y;
    logic [1:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] a;
    logic       err;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    unshifter_seq #(.OUT_W(4), .SH_W(2), .IN_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [6:0] vy;
        logic [1:0] vb;
        logic [3:0] va;
        logic       ve;
        int         stall;
        bit         probe;
        string      tag;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One complete transaction: accept, wait for result, hold under optional
    // backpressure (optionally presenting a competing input), then release.
    task automatic run_txn(input logic [6:0] ty, input logic [1:0] tbv,
                           input logic [3:0] ea, input logic ee,
                           input int stall, input bit probe, input string tag);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check({tag, "_accept_ready"}, int'(in_ready), 1);
        y        = ty;
        b        = tbv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        // Garbage on the inputs must be ignored while not idle.
        y = 7'b1010101;
        b = 2'd1;
        lat = 1;
        while (!out_valid && lat < 20) begin
            check({tag, "_in_ready_while_shift"}, int'(in_ready), 0);
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, int'(tbv) + 1);
        check({tag, "_a"}, int'(a), int'(ea));
        check({tag, "_err"}, int'(err), int'(ee));
        check({tag, "_in_ready_done"}, int'(in_ready), 0);
        check({tag, "_busy_done"}, int'(busy), 1);
        for (int s = 0; s < stall; s++) begin
            if (probe) begin
                in_valid = 1'b1;
                y        = 7'b0000001;
                b        = 2'd0;
            end
            step();
            check({tag, "_hold_valid"}, int'(out_valid), 1);
            check({tag, "_hold_a"}, int'(a), int'(ea));
            check({tag, "_hold_err"}, int'(err), int'(ee));
            check({tag, "_hold_in_ready"}, int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_release_valid"}, int'(out_valid), 0);
        check({tag, "_release_in_ready"}, int'(in_ready), 1);
        check({tag, "_release_busy"}, int'(busy), 0);
    endtask

    // Independent monitor: models each accepted word and checks the result
    // and latency when the output handshake completes.
    logic       m_pend = 1'b0;
    logic       m_seen = 1'b0;
    logic [3:0] m_a;
    logic       m_e;
    int         m_k;
    int         m_b;
    int         m_first;

    task automatic mon_check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL mon_%s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
            $error("monitor mismatch on %s", name);
        end
    endtask

    always @(negedge clk) begin
        logic [6:0] mask;
        logic [6:0] sh;
        if (rst) begin
            m_pend = 1'b0;
            m_seen = 1'b0;
        end else begin
            if (out_valid && !m_pend)
                mon_check("unexpected_out_valid", int'(out_valid), 0);
            if (m_pend && out_valid && !m_seen) begin
                m_seen  = 1'b1;
                m_first = cyc;
            end
            if (m_pend && out_valid && out_ready) begin
                mon_check("a", int'(a), int'(m_a));
                mon_check("err", int'(err), int'(m_e));
                mon_check("latency", m_first - m_k, m_b + 1);
                m_pend = 1'b0;
                m_seen = 1'b0;
            end
            if (in_valid && in_ready) begin
                mask   = (7'd1 << b) - 7'd1;
                sh     = y >> b;
                m_a    = sh[3:0];
                m_e    = ((y & mask) != 7'd0) || (sh > 7'd15);
                m_k    = cyc;
                m_b    = int'(b);
                m_pend = 1'b1;
                m_seen = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] ty;
        int         guard;

        vecs[0] = '{7'b0101100, 2'd2, 4'b1011, 1'b0, 0, 1'b0, "legal_b2"};
        vecs[1] = '{7'b0001111, 2'd0, 4'b1111, 1'b0, 0, 1'b0, "zero_shift"};
        vecs[2] = '{7'b1000000, 2'd0, 4'b0000, 1'b1, 0, 1'b0, "upper_bit"};
        vecs[3] = '{7'b0101101, 2'd2, 4'b1011, 1'b1, 0, 1'b0, "lost_low"};
        vecs[4] = '{7'b1111000, 2'd3, 4'b1111, 1'b0, 0, 1'b0, "legal_b3"};
        vecs[5] = '{7'b0110000, 2'd3, 4'b0110, 1'b0, 5, 1'b1, "backpressure"};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        y         = '0;
        b         = '0;

        // Reset state
        step();
        step();
        step();
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_a", int'(a), 0);
        check("reset_err", int'(err), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        step();
        check("post_reset_in_ready", int'(in_ready), 1);

        // Directed table
        for (int i = 0; i < 6; i++)
            run_txn(vecs[i].vy, vecs[i].vb, vecs[i].va, vecs[i].ve,
                    vecs[i].stall, vecs[i].probe, vecs[i].tag);

        // Reset mid-operation: accept in cycle k, assert rst in cycle k+2.
        check("midrst_ready", int'(in_ready), 1);
        y        = 7'b1111000;
        b        = 2'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_a", int'(a), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        step();
        check("midrst_in_ready_after", int'(in_ready), 1);
        guard = 0;
        for (int s = 0; s < 6; s++) begin
            step();
            if (out_valid) guard++;
        end
        check("midrst_no_result", guard, 0);
        run_txn(7'b0101100, 2'd2, 4'b1011, 1'b0, 1, 1'b0, "after_midrst");

        // Exhaustive round trip with random output stalls
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
                ty = 7'(av) << bv;
                run_txn(ty, 2'(bv), 4'(av), 1'b0, int'($urandom_range(0, 3)), 1'b0, "round_trip");
            end
        end

        step();
        check("monitor_drained", int'(m_pend), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
